// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF definitions: controller state encoding, response status
// codes and the default datapath width. Also used by coprocessor bench models.
package cvxif_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_REG      = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_ILLEGAL = 2'b01,
        STATUS_TIMEOUT = 2'b10
    } status_e;

endpackage

// File: rtl/cvxif_timeout_cnt.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0
// disables the watchdog entirely (expire stays 0).
module cvxif_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] count;

    // Clear has priority so a state change always restarts the window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expire = ENABLED && en && (count == LAST);

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Core-side CV-X-IF initiator: one offload transaction at a time through
// issue, register and result handshakes, answered with one core response.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | ready for a core request
// ST_ISSUE    | instruction offered to the coprocessor
// ST_REG      | operands offered to the coprocessor
// ST_WAIT_RES | waiting for the coprocessor result
// ST_RESP     | response held toward the core until consumed
module cvxif_offload_ctrl
    import cvxif_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req_valid,
    output logic            core_req_ready,
    input  logic [XLEN-1:0] core_req_instr,
    input  logic [XLEN-1:0] core_req_rs0,
    input  logic [XLEN-1:0] core_req_rs1,
    output logic            core_resp_valid,
    input  logic            core_resp_ready,
    output logic [1:0]      core_resp_status,
    output logic [XLEN-1:0] core_resp_data,
    output logic            core_resp_writeback,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [XLEN-1:0] issue_req_instr,
    input  logic            issue_resp_accept,
    input  logic            issue_resp_writeback,
    input  logic [1:0]      issue_resp_register_read,
    output logic            register_valid,
    input  logic            register_ready,
    output logic [XLEN-1:0] register_rs0,
    output logic [XLEN-1:0] register_rs1,
    output logic [1:0]      register_rs_valid,
    input  logic            result_valid,
    output logic            result_ready,
    input  logic [XLEN-1:0] result_data
);

    state_e          state, state_next;
    status_e         status_q, status_next;
    logic [XLEN-1:0] instr_q, rs0_q, rs1_q, data_q;
    logic [1:0]      rs_valid_q;
    logic            wb_q, resp_wb_q;
    logic            cnt_clr, cnt_en, expire;

    cvxif_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (expire)
    );

    // Next state and response status; a handshake always beats the timeout.
    always_comb begin
        state_next  = state;
        status_next = status_q;
        case (state)
            ST_IDLE: begin
                if (core_req_valid) begin
                    state_next  = ST_ISSUE;
                    status_next = STATUS_OK;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    if (!issue_resp_accept) begin
                        state_next  = ST_RESP;
                        status_next = STATUS_ILLEGAL;
                    end else if (issue_resp_register_read != 2'b00) begin
                        state_next = ST_REG;
                    end else if (issue_resp_writeback) begin
                        state_next = ST_WAIT_RES;
                    end else begin
                        state_next = ST_RESP;
                    end
                end else if (expire) begin
                    state_next  = ST_RESP;
                    status_next = STATUS_TIMEOUT;
                end
            end
            ST_REG: begin
                if (register_ready) begin
                    state_next = wb_q ? ST_WAIT_RES : ST_RESP;
                end else if (expire) begin
                    state_next  = ST_RESP;
                    status_next = STATUS_TIMEOUT;
                end
            end
            ST_WAIT_RES: begin
                if (result_valid) begin
                    state_next = ST_RESP;
                end else if (expire) begin
                    state_next  = ST_RESP;
                    status_next = STATUS_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (core_resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Watchdog runs only while waiting on the coprocessor, restarts per state.
    always_comb begin
        cnt_en  = (state == ST_ISSUE) || (state == ST_REG) || (state == ST_WAIT_RES);
        cnt_clr = (state_next != state);
    end

    // State register plus the latched request, issue response and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            status_q   <= STATUS_OK;
            instr_q    <= '0;
            rs0_q      <= '0;
            rs1_q      <= '0;
            data_q     <= '0;
            rs_valid_q <= 2'b00;
            wb_q       <= 1'b0;
            resp_wb_q  <= 1'b0;
        end else begin
            state    <= state_next;
            status_q <= status_next;
            case (state)
                ST_IDLE: begin
                    if (core_req_valid) begin
                        instr_q    <= core_req_instr;
                        rs0_q      <= core_req_rs0;
                        rs1_q      <= core_req_rs1;
                        data_q     <= '0;
                        rs_valid_q <= 2'b00;
                        wb_q       <= 1'b0;
                        resp_wb_q  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        wb_q       <= issue_resp_writeback;
                        rs_valid_q <= issue_resp_register_read;
                    end
                end
                ST_WAIT_RES: begin
                    if (result_valid) begin
                        data_q    <= result_data;
                        resp_wb_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; everything is forced low while reset is asserted.
    always_comb begin
        core_req_ready      = !rst && (state == ST_IDLE);
        issue_valid         = !rst && (state == ST_ISSUE);
        register_valid      = !rst && (state == ST_REG);
        result_ready        = !rst && (state == ST_WAIT_RES);
        core_resp_valid     = !rst && (state == ST_RESP);
        core_resp_status    = rst ? 2'b00 : status_q;
        core_resp_data      = rst ? '0 : data_q;
        core_resp_writeback = !rst && resp_wb_q;
        issue_req_instr     = rst ? '0 : instr_q;
        register_rs0        = rst ? '0 : rs0_q;
        register_rs1        = rst ? '0 : rs1_q;
        register_rs_valid   = rst ? 2'b00 : rs_valid_q;
    end

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Directed bench for cvxif_offload_ctrl with a short watchdog (8 cycles).
module tb_cvxif_offload_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [31:0] core_req_instr;
    logic [31:0] core_req_rs0;
    logic [31:0] core_req_rs1;
    logic        core_resp_valid;
    logic        core_resp_ready;
    logic [1:0]  core_resp_status;
    logic [31:0] core_resp_data;
    logic        core_resp_writeback;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_req_instr;
    logic        issue_resp_accept;
    logic        issue_resp_writeback;
    logic [1:0]  issue_resp_register_read;
    logic        register_valid;
    logic        register_ready;
    logic [31:0] register_rs0;
    logic [31:0] register_rs1;
    logic [1:0]  register_rs_valid;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    int checks = 0;
    int errors = 0;

    logic [137:0] all_out;
    assign all_out = {core_req_ready, core_resp_valid, core_resp_status, core_resp_data,
                      core_resp_writeback, issue_valid, issue_req_instr, register_valid,
                      register_rs0, register_rs1, register_rs_valid, result_ready};

    cvxif_offload_ctrl #(
        .XLEN(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .core_req_valid           (core_req_valid),
        .core_req_ready           (core_req_ready),
        .core_req_instr           (core_req_instr),
        .core_req_rs0             (core_req_rs0),
        .core_req_rs1             (core_req_rs1),
        .core_resp_valid          (core_resp_valid),
        .core_resp_ready          (core_resp_ready),
        .core_resp_status         (core_resp_status),
        .core_resp_data           (core_resp_data),
        .core_resp_writeback      (core_resp_writeback),
        .issue_valid              (issue_valid),
        .issue_ready              (issue_ready),
        .issue_req_instr          (issue_req_instr),
        .issue_resp_accept        (issue_resp_accept),
        .issue_resp_writeback     (issue_resp_writeback),
        .issue_resp_register_read (issue_resp_register_read),
        .register_valid           (register_valid),
        .register_ready           (register_ready),
        .register_rs0             (register_rs0),
        .register_rs1             (register_rs1),
        .register_rs_valid        (register_rs_valid),
        .result_valid             (result_valid),
        .result_ready             (result_ready),
        .result_data              (result_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req_valid           = 1'b0;
        core_req_instr           = '0;
        core_req_rs0             = '0;
        core_req_rs1             = '0;
        core_resp_ready          = 1'b0;
        issue_ready              = 1'b0;
        issue_resp_accept        = 1'b0;
        issue_resp_writeback     = 1'b0;
        issue_resp_register_read = 2'b00;
        register_ready           = 1'b0;
        result_valid             = 1'b0;
        result_data              = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h want 0", all_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (core_req_ready !== 1'b1 || issue_valid !== 1'b0 || core_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle req_ready=%b issue_valid=%b resp_valid=%b want 1 0 0",
                     core_req_ready, issue_valid, core_resp_valid);
        end
        tick();
    endtask

    task automatic test_basic();
        clear_inputs();
        issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1;
        issue_resp_register_read = 2'b11; register_ready = 1'b1;
        result_valid = 1'b1; result_data = 32'd7;
        core_req_valid = 1'b1; core_req_instr = 32'h0000_500B;
        core_req_rs0 = 32'd3; core_req_rs1 = 32'd4;
        checks++;
        if (core_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_req_ready got %b want 1", core_req_ready);
        end
        tick();
        core_req_valid = 1'b0; core_req_instr = '0; core_req_rs0 = '0; core_req_rs1 = '0;
        checks++;
        if (issue_valid !== 1'b1 || issue_req_instr !== 32'h0000_500B || result_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_issue valid=%b instr=%h res_ready=%b want 1 0000500b 0",
                     issue_valid, issue_req_instr, result_ready);
        end
        tick();
        checks++;
        if (register_valid !== 1'b1 || register_rs0 !== 32'd3 || register_rs1 !== 32'd4 ||
            register_rs_valid !== 2'b11) begin
            errors++;
            $display("FAIL basic_reg valid=%b rs0=%0d rs1=%0d rs_valid=%b want 1 3 4 11",
                     register_valid, register_rs0, register_rs1, register_rs_valid);
        end
        tick();
        checks++;
        if (result_ready !== 1'b1 || core_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait res_ready=%b resp_valid=%b want 1 0", result_ready, core_resp_valid);
        end
        tick();
        checks++;
        if (core_resp_valid !== 1'b1 || core_resp_data !== 32'd7 || core_resp_status !== 2'b00 ||
            core_resp_writeback !== 1'b1) begin
            errors++;
            $display("FAIL basic_resp valid=%b data=%0d status=%b wb=%b want 1 7 00 1",
                     core_resp_valid, core_resp_data, core_resp_status, core_resp_writeback);
        end
        core_resp_ready = 1'b1;
        tick();
        checks++;
        if (core_resp_valid !== 1'b0 || core_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done resp_valid=%b req_ready=%b want 0 1", core_resp_valid, core_req_ready);
        end
    endtask

    task automatic test_illegal();
        clear_inputs();
        issue_ready = 1'b1; issue_resp_accept = 1'b0; issue_resp_writeback = 1'b1;
        issue_resp_register_read = 2'b11; register_ready = 1'b1;
        core_req_valid = 1'b1; core_req_instr = 32'hFFFF_FFFF;
        tick();
        core_req_valid = 1'b0;
        checks++;
        if (issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_issue got %b want 1", issue_valid);
        end
        tick();
        checks++;
        if (register_valid !== 1'b0 || core_resp_valid !== 1'b1 || core_resp_status !== 2'b01 ||
            core_resp_data !== 32'd0 || core_resp_writeback !== 1'b0) begin
            errors++;
            $display("FAIL illegal_resp regv=%b valid=%b status=%b data=%h wb=%b want 0 1 01 0 0",
                     register_valid, core_resp_valid, core_resp_status, core_resp_data, core_resp_writeback);
        end
        core_resp_ready = 1'b1;
        tick();
        checks++;
        if (core_req_ready !== 1'b1 || register_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_done req_ready=%b regv=%b want 1 0", core_req_ready, register_valid);
        end
    endtask

    task automatic test_no_operands();
        clear_inputs();
        issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b0;
        issue_resp_register_read = 2'b00; register_ready = 1'b1; result_valid = 1'b1;
        result_data = 32'h1111_1111;
        core_req_valid = 1'b1; core_req_instr = 32'h0000_400B;
        tick();
        core_req_valid = 1'b0;
        tick();
        checks++;
        if (core_resp_valid !== 1'b1 || core_resp_status !== 2'b00 || core_resp_data !== 32'd0 ||
            core_resp_writeback !== 1'b0) begin
            errors++;
            $display("FAIL noop_resp valid=%b status=%b data=%h wb=%b want 1 00 0 0",
                     core_resp_valid, core_resp_status, core_resp_data, core_resp_writeback);
        end
        core_resp_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back_stall();
        clear_inputs();
        issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1; issue_resp_register_read = 2'b01;
        core_req_valid = 1'b1; core_req_instr = 32'h1234_5678;
        core_req_rs0 = 32'hAAAA_0001; core_req_rs1 = 32'h5555_0002;
        tick();
        core_req_valid = 1'b0; core_req_instr = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || issue_req_instr !== 32'h1234_5678) begin
                errors++;
                $display("FAIL stall_issue[%0d] valid=%b instr=%h want 1 12345678", i, issue_valid, issue_req_instr);
            end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0; issue_resp_accept = 1'b0; issue_resp_register_read = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) register_ready = 1'b1;
            checks++;
            if (register_valid !== 1'b1 || register_rs0 !== 32'hAAAA_0001 ||
                register_rs1 !== 32'h5555_0002 || register_rs_valid !== 2'b01) begin
                errors++;
                $display("FAIL stall_reg[%0d] valid=%b rs0=%h rs1=%h rsv=%b want 1 aaaa0001 55550002 01",
                         i, register_valid, register_rs0, register_rs1, register_rs_valid);
            end
            tick();
        end
        register_ready = 1'b0;
        result_valid = 1'b1; result_data = 32'hDEAD_BEEF;
        tick();
        result_valid = 1'b0; result_data = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) core_resp_ready = 1'b1;
            checks++;
            if (core_resp_valid !== 1'b1 || core_resp_data !== 32'hDEAD_BEEF ||
                core_resp_status !== 2'b00 || core_resp_writeback !== 1'b1) begin
                errors++;
                $display("FAIL stall_resp[%0d] valid=%b data=%h status=%b wb=%b want 1 deadbeef 00 1",
                         i, core_resp_valid, core_resp_data, core_resp_status, core_resp_writeback);
            end
            tick();
        end
        core_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (core_resp_valid !== 1'b0 || core_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_single[%0d] resp_valid=%b req_ready=%b want 0 1",
                         i, core_resp_valid, core_req_ready);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_inputs();
        issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1;
        core_req_valid = 1'b1; core_req_instr = 32'h0000_700B;
        tick();
        core_req_valid = 1'b0;
        tick();
        n = 0;
        while (result_ready === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want 8", n);
        end
        checks++;
        if (core_resp_valid !== 1'b1 || core_resp_status !== 2'b10 || core_resp_data !== 32'd0 ||
            core_resp_writeback !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp valid=%b status=%b data=%h wb=%b want 1 10 0 0",
                     core_resp_valid, core_resp_status, core_resp_data, core_resp_writeback);
        end
        result_valid = 1'b1; result_data = 32'h99;
        core_resp_ready = 1'b1;
        tick();
        core_resp_ready = 1'b0;
        tick();
        checks++;
        if (result_ready !== 1'b0 || core_resp_valid !== 1'b0 || core_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stray res_ready=%b resp_valid=%b req_ready=%b want 0 0 1",
                     result_ready, core_resp_valid, core_req_ready);
        end
        result_valid = 1'b0;
        core_req_valid = 1'b1;
        tick();
        core_req_valid = 1'b0;
        tick();
        result_valid = 1'b1; result_data = 32'h42;
        tick();
        result_valid = 1'b0;
        checks++;
        if (core_resp_valid !== 1'b1 || core_resp_status !== 2'b00 || core_resp_data !== 32'h42 ||
            core_resp_writeback !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover valid=%b status=%b data=%h wb=%b want 1 00 42 1",
                     core_resp_valid, core_resp_status, core_resp_data, core_resp_writeback);
        end
        core_resp_ready = 1'b1;
        tick();
        core_resp_ready = 1'b0;
        core_req_valid = 1'b1;
        tick();
        core_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (result_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_last_cycle res_ready got %b want 1", result_ready);
        end
        result_valid = 1'b1; result_data = 32'h77;
        tick();
        result_valid = 1'b0;
        checks++;
        if (core_resp_valid !== 1'b1 || core_resp_status !== 2'b00 || core_resp_data !== 32'h77) begin
            errors++;
            $display("FAIL timeout_tie valid=%b status=%b data=%h want 1 00 77",
                     core_resp_valid, core_resp_status, core_resp_data);
        end
        core_resp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1;
        issue_resp_register_read = 2'b11;
        core_req_valid = 1'b1; core_req_instr = 32'h0000_600B;
        core_req_rs0 = 32'd5; core_req_rs1 = 32'd6;
        tick();
        core_req_valid = 1'b0;
        tick();
        checks++;
        if (register_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_reg got %b want 1", register_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %0h want 0", all_out);
        end
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rstmid_held got %0h want 0", all_out);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (core_req_ready !== 1'b1 || core_resp_valid !== 1'b0 || register_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after[%0d] req_ready=%b resp_valid=%b regv=%b want 1 0 0",
                         i, core_req_ready, core_resp_valid, register_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_no_operands();
        test_back_to_back_stall();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
